usb_byte_fifo: RTL and testbench
================================

Name: usb_byte_fifo

Overview:
Parametrised circular byte FIFO that buffers USB packet payloads between the RX/TX packet engines (byte-wide) and the AHB-Lite slave (1..WORD_BYTES bytes per access).
Next generation of the endpoint data buffer, with these additions:
- true wrap-around addressing
- full/empty flags
- all-or-nothing access checks
- sticky overflow/underflow error flags
- concurrent read and write in one cycle
It sits between the AHB-Lite slave, the protocol controller, and the RX/TX engines.

Parameters:
DEPTH, 64, byte capacity; power of two, >= 2*WORD_BYTES.
WORD_BYTES, 4, AHB-side word width in bytes; power of two, 1..8.
ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden).
SIZE_W, max(1,$clog2(WORD_BYTES)), data_size width (derived).

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
clear  in  1  protocol controller flush
buffer_reserved  in  1  1 = AHB owns write side, 0 = RX owns write side
store_rx_packet_data  in  1  RX byte write strobe
rx_packet_data  in  8  RX byte
store_tx_data  in  1  AHB write strobe
tx_data  in  8*WORD_BYTES  AHB write data, byte 0 in bits [7:0]
get_rx_data  in  1  AHB read strobe
data_size  in  SIZE_W  AHB access size, bytes = data_size+1
get_tx_packet_data  in  1  TX byte read strobe
rx_data  out  8*WORD_BYTES  AHB read data, registered
tx_packet_data  out  8  TX byte, registered
buffer_occupancy  out  ADDR_W+1  bytes stored, 0..DEPTH
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0
overflow_err  out  1  sticky, rejected write
underflow_err  out  1  sticky, rejected read

Behaviour:
- Reset (async, n_rst low):
  - wr_ptr, rd_ptr, occupancy, rx_data, tx_packet_data, full, overflow_err, underflow_err = 0; empty = 1.
  - Storage array is not reset (RAM-inferable).
- Pointers are ADDR_W bits and advance modulo DEPTH. Byte k of a multi-byte access uses address (ptr+k) mod DEPTH.
- Occupancy is a separate ADDR_W+1 counter; never derived from pointer difference.
- Write selection:
  - store_tx_data is honoured only when buffer_reserved=1.
  - store_rx_packet_data is honoured only when buffer_reserved=0.
  - The non-owning strobe is ignored silently.
  - Write size n_w = data_size+1 (AHB) or 1 (RX).
- Write accept: only if DEPTH - occupancy >= n_w, judged on the current-cycle occupancy (a same-cycle read does not free space).
  - Reject: no bytes written, wr_ptr unchanged, overflow_err set next cycle.
- Read selection: get_rx_data has priority over get_tx_packet_data; when both are high, the TX strobe is ignored. Read size n_r = data_size+1 (AHB) or 1 (TX).
- Read accept: only if occupancy >= n_r on the current cycle (no write-to-read bypass).
  - Accepted read, one-cycle latency: rx_data gets bytes rd_ptr..rd_ptr+n_r-1 in ascending lanes, with unused upper lanes 0; tx_packet_data gets the byte at rd_ptr.
  - Reject: rd_ptr unchanged, underflow_err set next cycle.
  - rx_data and tx_packet_data hold their last value when no accepted read occurs.
- Simultaneous accepted write and read: both complete; occupancy_next = occupancy + n_w - n_r; full and empty are registered from occupancy_next.
- clear has the highest priority:
  - Next cycle: pointers, occupancy and both error flags are 0, empty = 1.
  - Same-cycle writes and reads are discarded.
  - Output data registers and storage are untouched.
- Error flags stay high until clear or reset.
- Reset asserted mid-access aborts the access; state returns to reset values immediately.

Decomposition:
- Package usb_buf_pkg:
  - default DEPTH/WORD_BYTES constants
  - typedef for the access-size encoding
  - function size_to_bytes(data_size)
- Sub-module fifo_ptr: ADDR_W-bit wrapping pointer register with clear and advance-by-n inputs, instantiated twice (wr_ptr, rd_ptr).

Test Plan (DEPTH=64, WORD_BYTES=4):
1. Reset -> occupancy 0, empty=1, full=0, rx_data=0, tx_packet_data=0, both error flags 0.
2. AHB write, buffer_reserved=1, data_size=3, tx_data=0xDDCCBBAA -> occupancy 4; then four get_tx_packet_data pulses -> tx_packet_data = AA, BB, CC, DD, each one cycle after its pulse; then empty=1.
3. Wrap:
   - Stimulus: 62 RX bytes written then 62 read (pointers = 62); AHB write size 3 of 0x44332211; get_rx_data size 3.
   - Response: rx_data=0x44332211, rd_ptr=2, occupancy 0.
4. Full/overflow:
   - 64 RX writes -> full=1, occupancy 64.
   - 65th write -> ignored, overflow_err=1.
   - After one read (occupancy 63), AHB write data_size=1 -> rejected, occupancy 63.
5. Underflow: occupancy 2, get_rx_data data_size=3 -> underflow_err=1, rx_data unchanged, occupancy 2.
6. Concurrency and clear:
   - Occupancy 5, RX write + get_tx_packet_data in one cycle -> occupancy stays 5, correct byte out.
   - clear with store_rx_packet_data high -> occupancy 0, errors 0, write discarded.

Source files
------------

// File: rtl/usb_buf_pkg.sv
// ------------------------------------------------------------------------
// usb_buf_pkg : shared constants and access-size helpers for the USB buffer
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package usb_buf_pkg;

  localparam int DEPTH_DEFAULT      = 64;
  localparam int WORD_BYTES_DEFAULT = 4;

  // Widest size encoding needed for an 8-byte word; narrower configurations
  // zero-extend into it.
  localparam int SIZE_ENC_W = 3;

  typedef logic [SIZE_ENC_W-1:0] size_enc_t;
  typedef logic [SIZE_ENC_W:0]   size_bytes_t;

  function automatic size_bytes_t size_to_bytes(input size_enc_t data_size);
    return size_bytes_t'({1'b0, data_size}) + size_bytes_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ptr.sv
// ------------------------------------------------------------------------
// fifo_ptr : wrapping buffer pointer with synchronous clear and advance-by-n
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module fifo_ptr
  import usb_buf_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] step,
  output logic [ADDR_W-1:0] ptr
);

  // Natural ADDR_W-bit overflow gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr + step;
    end
  end

endmodule

`default_nettype wire

// File: rtl/usb_byte_fifo.sv
// ------------------------------------------------------------------------
// usb_byte_fifo : circular byte FIFO between the AHB slave and USB RX/TX engines
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module usb_byte_fifo
  import usb_buf_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int WORD_BYTES = WORD_BYTES_DEFAULT,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int SIZE_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    buffer_reserved,
  input  logic                    store_rx_packet_data,
  input  logic [7:0]              rx_packet_data,
  input  logic                    store_tx_data,
  input  logic [8*WORD_BYTES-1:0] tx_data,
  input  logic                    get_rx_data,
  input  logic [SIZE_W-1:0]       data_size,
  input  logic                    get_tx_packet_data,
  output logic [8*WORD_BYTES-1:0] rx_data,
  output logic [7:0]              tx_packet_data,
  output logic [ADDR_W:0]         buffer_occupancy,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow_err,
  output logic                    underflow_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] c_depth      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_word_bytes = CNT_W'(WORD_BYTES);
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

  logic [7:0]              r_mem [DEPTH];
  logic [CNT_W-1:0]        r_occ;
  logic [ADDR_W-1:0]       w_wr_ptr;
  logic [ADDR_W-1:0]       w_rd_ptr;

  size_enc_t               w_size_enc;
  logic [CNT_W-1:0]        w_ahb_n;
  logic [CNT_W-1:0]        w_wr_n;
  logic [CNT_W-1:0]        w_rd_n;
  logic [CNT_W-1:0]        w_free;
  logic [CNT_W-1:0]        w_occ_next;
  logic                    w_wr_ahb;
  logic                    w_wr_req;
  logic                    w_wr_ok;
  logic                    w_rd_ahb;
  logic                    w_rd_tx;
  logic                    w_rd_req;
  logic                    w_rd_ok;
  logic [7:0]              w_wr_lane [WORD_BYTES];
  logic [8*WORD_BYTES-1:0] w_rd_word;

  // Access size decode, clamped so an out-of-range size never exceeds a word.
  always_comb begin
    w_size_enc                = '0;
    w_size_enc[SIZE_W-1:0]    = data_size;
    w_ahb_n                   = CNT_W'(size_to_bytes(w_size_enc));
    if (w_ahb_n > c_word_bytes) begin
      w_ahb_n = c_word_bytes;
    end
  end

  // Write side: only the current owner of the write port is considered.
  always_comb begin
    w_wr_ahb = buffer_reserved & store_tx_data;
    w_wr_req = w_wr_ahb | (~buffer_reserved & store_rx_packet_data);
    w_wr_n   = w_wr_ahb ? w_ahb_n : c_one;
    w_free   = c_depth - r_occ;
    w_wr_ok  = w_wr_req && (w_free >= w_wr_n);
  end

  // Read side: AHB read wins over the TX engine when both strobe together.
  always_comb begin
    w_rd_ahb = get_rx_data;
    w_rd_tx  = get_tx_packet_data & ~get_rx_data;
    w_rd_req = w_rd_ahb | w_rd_tx;
    w_rd_n   = w_rd_ahb ? w_ahb_n : c_one;
    w_rd_ok  = w_rd_req && (r_occ >= w_rd_n);
  end

  always_comb begin
    if (clear) begin
      w_occ_next = '0;
    end else begin
      w_occ_next = r_occ + (w_wr_ok ? w_wr_n : '0) - (w_rd_ok ? w_rd_n : '0);
    end
  end

  always_comb begin
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (w_wr_ahb) begin
        w_wr_lane[k] = tx_data[8*k +: 8];
      end else begin
        w_wr_lane[k] = (k == 0) ? rx_packet_data : 8'h00;
      end
    end
  end

  // Lanes beyond the access size read back as zero.
  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (CNT_W'(k) < w_rd_n) begin
        w_rd_word[8*k +: 8] = r_mem[w_rd_ptr + ADDR_W'(k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok && !clear) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (CNT_W'(k) < w_wr_n) begin
          r_mem[w_wr_ptr + ADDR_W'(k)] <= w_wr_lane[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_occ          <= '0;
      full           <= 1'b0;
      empty          <= 1'b1;
      overflow_err   <= 1'b0;
      underflow_err  <= 1'b0;
      rx_data        <= '0;
      tx_packet_data <= '0;
    end else begin
      r_occ <= w_occ_next;
      full  <= (w_occ_next == c_depth);
      empty <= (w_occ_next == '0);
      if (clear) begin
        overflow_err  <= 1'b0;
        underflow_err <= 1'b0;
      end else begin
        if (w_wr_req && !w_wr_ok) begin
          overflow_err <= 1'b1;
        end
        if (w_rd_req && !w_rd_ok) begin
          underflow_err <= 1'b1;
        end
        if (w_rd_ok && w_rd_ahb) begin
          rx_data <= w_rd_word;
        end
        if (w_rd_ok && w_rd_tx) begin
          tx_packet_data <= r_mem[w_rd_ptr];
        end
      end
    end
  end

  assign buffer_occupancy = r_occ;

  fifo_ptr #(
    .ADDR_W (ADDR_W)
  ) u_wr_ptr (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (clear),
    .advance (w_wr_ok),
    .step    (ADDR_W'(w_wr_n)),
    .ptr     (w_wr_ptr)
  );

  fifo_ptr #(
    .ADDR_W (ADDR_W)
  ) u_rd_ptr (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (clear),
    .advance (w_rd_ok),
    .step    (ADDR_W'(w_rd_n)),
    .ptr     (w_rd_ptr)
  );

endmodule

`default_nettype wire

// File: tb/tb_usb_byte_fifo.sv
// ------------------------------------------------------------------------
// tb_usb_byte_fifo : scoreboard bench for usb_byte_fifo (DEPTH=64, WORD_BYTES=4)
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_usb_byte_fifo;

  localparam int DEPTH      = 64;
  localparam int WORD_BYTES = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear;
  logic        buffer_reserved;
  logic        store_rx_packet_data;
  logic [7:0]  rx_packet_data;
  logic        store_tx_data;
  logic [31:0] tx_data;
  logic        get_rx_data;
  logic [1:0]  data_size;
  logic        get_tx_packet_data;
  logic [31:0] rx_data;
  logic [7:0]  tx_packet_data;
  logic [6:0]  buffer_occupancy;
  logic        full;
  logic        empty;
  logic        overflow_err;
  logic        underflow_err;

  usb_byte_fifo #(
    .DEPTH      (DEPTH),
    .WORD_BYTES (WORD_BYTES)
  ) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .buffer_reserved      (buffer_reserved),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .data_size            (data_size),
    .get_tx_packet_data   (get_tx_packet_data),
    .rx_data              (rx_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .full                 (full),
    .empty                (empty),
    .overflow_err         (overflow_err),
    .underflow_err        (underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ahb;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mdl[$];
  logic        m_ovf;
  logic        m_unf;
  logic [31:0] hold_rx;
  logic [7:0]  hold_tx;
  int          err_cnt = 0;
  int          chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; the reference model decides acceptance from the
  // pre-edge byte count and queues any expected read result.
  task automatic cyc(input logic clr, input logic res, input logic st_rx, input logic [7:0] rxb,
                     input logic st_tx, input logic [31:0] txd, input logic g_rx,
                     input logic [1:0] sz, input logic g_tx);
    int          occ0;
    int          nw;
    int          nr;
    logic        wr_req;
    logic        rd_req;
    logic [31:0] word;
    exp_t        e;
    occ0   = mdl.size();
    wr_req = res ? st_tx : st_rx;
    nw     = res ? int'(sz) + 1 : 1;
    rd_req = g_rx | g_tx;
    nr     = g_rx ? int'(sz) + 1 : 1;
    if (clr) begin
      mdl.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (rd_req) begin
        if (occ0 >= nr) begin
          word = '0;
          for (int k = 0; k < nr; k++) word[8*k +: 8] = mdl[k];
          e.is_ahb = g_rx;
          e.data   = word;
          exp_q.push_back(e);
          for (int k = 0; k < nr; k++) void'(mdl.pop_front());
        end else begin
          m_unf = 1'b1;
        end
      end
      if (wr_req) begin
        if (DEPTH - occ0 >= nw) begin
          for (int k = 0; k < nw; k++) mdl.push_back(res ? txd[8*k +: 8] : rxb);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    clear                = clr;
    buffer_reserved      = res;
    store_rx_packet_data = st_rx;
    rx_packet_data       = rxb;
    store_tx_data        = st_tx;
    tx_data              = txd;
    get_rx_data          = g_rx;
    data_size            = sz;
    get_tx_packet_data   = g_tx;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.is_ahb) hold_rx = e.data;
      else          hold_tx = e.data[7:0];
    end
    chk("rx_data", rx_data, hold_rx);
    chk("tx_packet_data", 32'(tx_packet_data), 32'(hold_tx));
    chk("occupancy", 32'(buffer_occupancy), 32'(mdl.size()));
    chk("full", 32'(full), 32'(mdl.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mdl.size() == 0));
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
    chk("underflow_err", 32'(underflow_err), 32'(m_unf));
  endtask

  task automatic idle();           cyc(0, 0, 0, 8'h00, 0, 32'h0, 0, 2'd0, 0); endtask
  task automatic rx_wr(input logic [7:0] b); cyc(0, 0, 1, b, 0, 32'h0, 0, 2'd0, 0); endtask
  task automatic tx_rd();          cyc(0, 0, 0, 8'h00, 0, 32'h0, 0, 2'd0, 1); endtask
  task automatic ahb_wr(input logic [1:0] sz, input logic [31:0] d); cyc(0, 1, 0, 8'h00, 1, d, 0, sz, 0); endtask
  task automatic ahb_rd(input logic [1:0] sz); cyc(0, 1, 0, 8'h00, 0, 32'h0, 1, sz, 0); endtask
  task automatic flush();          cyc(1, 0, 0, 8'h00, 0, 32'h0, 0, 2'd0, 0); endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0; clear = 1'b0; buffer_reserved = 1'b0;
    store_rx_packet_data = 1'b0; rx_packet_data = 8'h00;
    store_tx_data = 1'b0; tx_data = 32'h0;
    get_rx_data = 1'b0; data_size = 2'd0; get_tx_packet_data = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; hold_rx = 32'h0; hold_tx = 8'h00;

    #12;
    chk("rst_occupancy", 32'(buffer_occupancy), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_tx_packet_data", 32'(tx_packet_data), 32'd0);
    chk("rst_overflow_err", 32'(overflow_err), 32'd0);
    chk("rst_underflow_err", 32'(underflow_err), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // AHB word in, TX bytes out in lane order
    ahb_wr(2'd3, 32'hDDCCBBAA);
    repeat (4) tx_rd();
    idle();

    // Pointer wrap for a multi-byte access straddling the end of storage
    for (int i = 0; i < 62; i++) rx_wr(8'(i + 1));
    repeat (62) tx_rd();
    ahb_wr(2'd3, 32'h44332211);
    ahb_rd(2'd3);
    chk("wrap_word", rx_data, 32'h44332211);
    rx_wr(8'h5A);
    tx_rd();

    // Partial-size accesses zero the unused upper lanes
    ahb_wr(2'd3, 32'h87654321);
    ahb_rd(2'd1);
    ahb_rd(2'd0);
    ahb_rd(2'd0);
    // Non-owning strobes are ignored
    cyc(0, 1, 1, 8'h77, 0, 32'h0, 0, 2'd0, 0);
    cyc(0, 0, 0, 8'h00, 1, 32'h12345678, 0, 2'd3, 0);

    // Fill, overflow, write rejected at full even with a same-cycle read
    for (int i = 0; i < DEPTH; i++) rx_wr(8'(i) ^ 8'hA5);
    rx_wr(8'hEE);
    cyc(0, 0, 1, 8'hEF, 0, 32'h0, 0, 2'd0, 1);
    ahb_wr(2'd1, 32'h0000BEEF);
    ahb_wr(2'd0, 32'h000000C3);
    repeat (3) ahb_rd(2'd3);
    flush();

    // Underflow keeps rx_data; AHB read wins over a same-cycle TX read
    rx_wr(8'h10);
    rx_wr(8'h20);
    ahb_rd(2'd3);
    rx_wr(8'h30);
    cyc(0, 1, 0, 8'h00, 0, 32'h0, 1, 2'd1, 1);
    tx_rd();
    tx_rd();
    flush();

    // Concurrent write/read and clear discarding a same-cycle write
    for (int i = 0; i < 5; i++) rx_wr(8'hB0 + 8'(i));
    cyc(0, 0, 1, 8'hC5, 0, 32'h0, 0, 2'd0, 1);
    tx_rd();
    tx_rd();
    cyc(1, 0, 1, 8'hD1, 0, 32'h0, 0, 2'd0, 0);
    idle();
    tx_rd();

    // Asynchronous reset in the middle of an access
    rx_wr(8'h99);
    store_rx_packet_data = 1'b1;
    rx_packet_data       = 8'h9A;
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_occupancy", 32'(buffer_occupancy), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_tx_packet_data", 32'(tx_packet_data), 32'd0);
    mdl.delete();
    m_ovf = 1'b0; m_unf = 1'b0; hold_rx = 32'h0; hold_tx = 8'h00;
    @(negedge clk);
    n_rst = 1'b1;
    idle();
    tx_rd();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
